ship_control: RTL and testbench
===============================

// Module: ship_control
// PURPOSE
//  Downstream consumer of the keyboard block's level-held controls (shoot, forward, backward,
//  rotate_right, rotate_left). Integrates them once per game frame into ship heading, velocity
//  and wrapped screen position. Issues rate-limited fire pulses to the bullet/render logic.
//  Sits between the keyboard block and the renderer/bullet manager.
// PARAMETERS
//  TICK_DIV       833333  clk cycles per game tick (60 Hz at 50 MHz); benches use 4
//  SCREEN_W       160     playfield width, pixels
//  SCREEN_H       120     playfield height, pixels
//  ROT_PERIOD     4       ticks of held rotate per heading step (>=1)
//  MAX_V          32      |velocity| clamp per axis, 1/16 px/tick
//  FIRE_COOLDOWN  15      ticks blocked after a shot; auto-fire period = FIRE_COOLDOWN+1
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high
//  shoot         in   1   level, from keyboard block
//  forward       in   1   level, thrust along heading
//  backward      in   1   level, thrust against heading
//  rotate_right  in   1   level, clockwise
//  rotate_left   in   1   level, counter-clockwise
//  ship_x        out  8   integer pixel x = pos_x>>4
//  ship_y        out  7   integer pixel y = pos_y>>4
//  heading       out  4   0=up (-y), clockwise, 22.5 deg/step
//  fire          out  1   one-clk pulse: spawn bullet at ship_x/ship_y/heading
//  frame_tick    out  1   one-clk pulse per game tick
// BEHAVIOUR
//  - Reset: pos_x=80<<4 (1280), pos_y=60<<4 (960), heading=0, vx=vy=0, rot_cnt=0, cooldown=0,
//    fire=0, frame_tick=0, tick counter=0. ship_x=80, ship_y=60. Reset mid-operation wins over all.
//  - Tick: counter 0..TICK_DIV-1; frame_tick high for the clk where counter==TICK_DIV-1.
//    All game state below updates only on that clk; outputs valid the next clk.
//  - Inputs sampled only on tick clk; no edge detection (keyboard supplies levels).
//  - Rotation: exactly one rotate held -> rot_cnt++; on rot_cnt==ROT_PERIOD-1 heading+-1
//    (mod 16), rot_cnt=0. Both or neither held -> rot_cnt=0, heading unchanged.
//  - Direction LUT dir(h) = (round(8 sin), -round(8 cos)), components in {0,3,6,7,8} with sign;
//    h=0 -> (0,-8), h=4 -> (8,0), h=2 -> (6,-6).
//  - Velocity (signed 8b, 1/16 px/tick): thrust = forward XOR backward. forward: v+=dir(heading);
//    backward: v-=dir(heading); result clamped per axis to [-MAX_V,+MAX_V]. No net thrust:
//    friction, each axis moves 1 toward 0 (0 stays 0). LUT uses heading before this tick's rotate.
//  - Position: pos_x (12b unsigned, 8.4), pos_y (11b, 7.4). pos += v using pre-update v.
//    Compute in signed 13b; if <0 add SCREEN_*<<4; if >=SCREEN_*<<4 subtract it.
//    ship_x never >=160, ship_y never >=120.
//  - Fire: on tick, shoot && cooldown==0 -> fire=1 for that clk+1 only, cooldown=FIRE_COOLDOWN.
//    Else cooldown>0 -> cooldown--. Release does not clear cooldown. fire same clk as state update.
//  - No handshake; fire and frame_tick are single-cycle and never back-to-back within TICK_DIV.
// STRUCTURE
//  - asteroids_pkg: SCREEN_W/H, FRAC_BITS=4, heading width, dir_lut(h) function returning
//    signed dx/dy, clamp/wrap helper functions (shared with bullet and asteroid movers).
//  - Sub-module game_tick_gen (TICK_DIV counter -> frame_tick), reused by other movers.
//  - ship_control: rotate counter, velocity/position registers, fire cooldown.
// TESTING (TICK_DIV=4)
//  1 reset held 3 clk, inputs idle -> ship_x=80, ship_y=60, heading=0, fire=0 stable over 20 ticks.
//  2 forward 1 tick at h=0 -> vy=-8; next tick pos_y=952, ship_y=59; hold 10 ticks -> vy clamps -32;
//    release -> vy reaches 0 after 32 ticks, position then constant.
//  3 rotate_right 16 ticks -> heading=4; rotate_left 4 ticks -> 3; both held 20 ticks -> stays 3;
//    rotate_right 17 ticks from 15 -> wraps to 3 (4 steps, rot_cnt=0 excluded) check mod-16.
//  4 shoot held 40 ticks -> fire pulses on ticks 0,16,32 only, each exactly 1 clk wide;
//    release at tick 5, press at tick 10 -> next fire at tick 16.
//  5 h=4, forward held -> x increases to 159 then wraps to 0..1; h=0 -> y wraps 0 -> 119/118;
//    assert ship_x<160, ship_y<120 every clk.
//  6 reset for 1 clk mid-flight (vx=32, cooldown=9, heading=7) -> next clk all reset values,
//    fire=0; shoot held -> fires on first tick after reset.

Source files
------------

// File: rtl/asteroids_pkg.sv
// ---------------------------------------------------------------------------
// asteroids_pkg
//   Shared types, constants and helpers for the game movers (ship, bullets,
//   asteroids). Positions are unsigned fixed point with FRAC_BITS fraction
//   bits; velocities are signed 1/16 px per game tick.
// ---------------------------------------------------------------------------
package asteroids_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FRAC_BITS = 4;
  localparam int HEADING_W = 4;
  localparam int VEL_W     = 8;
  localparam int POS_X_W   = 12;   // 8.4 fixed point
  localparam int POS_Y_W   = 11;   // 7.4 fixed point
  localparam int COORD_W   = 13;   // signed working width for pos + vel

  typedef logic [HEADING_W-1:0]    heading_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    vel_t dx;
    vel_t dy;
  } dir_t;

  // Unit direction scaled by 8: (round(8 sin), -round(8 cos)); 0 = up (-y),
  // steps of 22.5 degrees clockwise.
  function automatic dir_t dir_lut(input heading_t h);
    dir_t d;
    case (h)
      4'd0:  begin d.dx =  8'sd0; d.dy = -8'sd8; end
      4'd1:  begin d.dx =  8'sd3; d.dy = -8'sd7; end
      4'd2:  begin d.dx =  8'sd6; d.dy = -8'sd6; end
      4'd3:  begin d.dx =  8'sd7; d.dy = -8'sd3; end
      4'd4:  begin d.dx =  8'sd8; d.dy =  8'sd0; end
      4'd5:  begin d.dx =  8'sd7; d.dy =  8'sd3; end
      4'd6:  begin d.dx =  8'sd6; d.dy =  8'sd6; end
      4'd7:  begin d.dx =  8'sd3; d.dy =  8'sd7; end
      4'd8:  begin d.dx =  8'sd0; d.dy =  8'sd8; end
      4'd9:  begin d.dx = -8'sd3; d.dy =  8'sd7; end
      4'd10: begin d.dx = -8'sd6; d.dy =  8'sd6; end
      4'd11: begin d.dx = -8'sd7; d.dy =  8'sd3; end
      4'd12: begin d.dx = -8'sd8; d.dy =  8'sd0; end
      4'd13: begin d.dx = -8'sd7; d.dy = -8'sd3; end
      4'd14: begin d.dx = -8'sd6; d.dy = -8'sd6; end
      default: begin d.dx = -8'sd3; d.dy = -8'sd7; end
    endcase
    return d;
  endfunction

  // Saturate a widened velocity sum to [-lim, +lim].
  function automatic vel_t clamp_vel(input logic signed [9:0] v,
                                     input logic signed [9:0] lim);
    if (v > lim)
      return vel_t'(lim);
    else if (v < -lim)
      return vel_t'(-lim);
    else
      return vel_t'(v);
  endfunction

  // Friction: one unit toward zero, zero stays zero.
  function automatic vel_t friction(input vel_t v);
    if (v > 0)
      return v - 8'sd1;
    else if (v < 0)
      return v + 8'sd1;
    else
      return v;
  endfunction

  // Toroidal wrap of a coordinate that moved by at most one span.
  function automatic coord_t wrap_coord(input coord_t p, input coord_t span);
    if (p < 0)
      return p + span;
    else if (p >= span)
      return p - span;
    else
      return p;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// ---------------------------------------------------------------------------
// game_tick_gen
//   Free-running divider producing one frame_tick pulse every TICK_DIV clks.
//   Ports:
//     clk        in  system clock
//     reset      in  synchronous, active-high
//     frame_tick out high for the single clk where the counter is TICK_DIV-1
// ---------------------------------------------------------------------------
module game_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign frame_tick = (cnt == LAST);

endmodule

// File: rtl/ship_control.sv
// ---------------------------------------------------------------------------
// ship_control
//   Integrates level-held keyboard controls once per game tick into ship
//   heading, velocity and wrapped screen position, and issues rate-limited
//   one-clk fire pulses.
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     shoot             level, request a bullet
//     forward/backward  level, thrust along / against heading
//     rotate_right/left level, clockwise / counter-clockwise rotation
//     ship_x, ship_y    integer pixel position
//     heading           0 = up, clockwise, 22.5 deg per step
//     fire              one-clk pulse, spawn bullet at ship_x/ship_y/heading
//     frame_tick        one-clk pulse per game tick
// ---------------------------------------------------------------------------
module ship_control
  import asteroids_pkg::*;
#(
  parameter int TICK_DIV      = 833333,
  parameter int ROT_PERIOD    = 4,
  parameter int MAX_V         = 32,
  parameter int FIRE_COOLDOWN = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shoot,
  input  logic                         forward,
  input  logic                         backward,
  input  logic                         rotate_right,
  input  logic                         rotate_left,
  output logic [POS_X_W-FRAC_BITS-1:0] ship_x,
  output logic [POS_Y_W-FRAC_BITS-1:0] ship_y,
  output heading_t                     heading,
  output logic                         fire,
  output logic                         frame_tick
);

  localparam int ROT_W = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
  localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam coord_t SPAN_X = coord_t'(SCREEN_W << FRAC_BITS);
  localparam coord_t SPAN_Y = coord_t'(SCREEN_H << FRAC_BITS);
  localparam logic [POS_X_W-1:0] POS_X_RST = POS_X_W'((SCREEN_W / 2) << FRAC_BITS);
  localparam logic [POS_Y_W-1:0] POS_Y_RST = POS_Y_W'((SCREEN_H / 2) << FRAC_BITS);
  localparam logic signed [9:0]  V_LIM     = 10'(MAX_V);

  logic                tick;
  logic [POS_X_W-1:0]  pos_x, pos_x_nxt;
  logic [POS_Y_W-1:0]  pos_y, pos_y_nxt;
  vel_t                vx, vy, vx_nxt, vy_nxt;
  heading_t            heading_nxt;
  logic [ROT_W-1:0]    rot_cnt, rot_cnt_nxt;
  logic [CD_W-1:0]     cooldown, cooldown_nxt;
  logic                fire_nxt;
  dir_t                dir;
  coord_t              sum_x, sum_y;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (tick)
  );

  assign frame_tick = tick;
  assign ship_x     = pos_x[POS_X_W-1:FRAC_BITS];
  assign ship_y     = pos_y[POS_Y_W-1:FRAC_BITS];

  // Next game state, committed only on the tick clk.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dir          = dir_lut(heading);  // pre-rotation heading drives thrust
    vx_nxt       = friction(vx);
    vy_nxt       = friction(vy);
    rot_cnt_nxt  = '0;
    heading_nxt  = heading;
    fire_nxt     = 1'b0;
    cooldown_nxt = cooldown;

    if (forward ^ backward) begin
      if (forward) begin
        vx_nxt = clamp_vel(10'(vx) + 10'(dir.dx), V_LIM);
        vy_nxt = clamp_vel(10'(vy) + 10'(dir.dy), V_LIM);
      end else begin
        vx_nxt = clamp_vel(10'(vx) - 10'(dir.dx), V_LIM);
        vy_nxt = clamp_vel(10'(vy) - 10'(dir.dy), V_LIM);
      end
    end

    // Position advances by the velocity held before this tick's update.
    sum_x     = wrap_coord($signed({1'b0, pos_x}) + coord_t'(vx), SPAN_X);
    sum_y     = wrap_coord($signed({2'b0, pos_y}) + coord_t'(vy), SPAN_Y);
    pos_x_nxt = sum_x[POS_X_W-1:0];
    pos_y_nxt = sum_y[POS_Y_W-1:0];

    // Exactly one rotate key counts toward a heading step; anything else
    // restarts the count.
    if (rotate_right ^ rotate_left) begin
      if (rot_cnt == ROT_W'(ROT_PERIOD - 1))
        heading_nxt = rotate_right ? heading + 1'b1 : heading - 1'b1;
      else
        rot_cnt_nxt = rot_cnt + 1'b1;
    end

    if (shoot && cooldown == '0) begin
      fire_nxt     = 1'b1;
      cooldown_nxt = CD_W'(FIRE_COOLDOWN);
    end else if (cooldown != '0) begin
      cooldown_nxt = cooldown - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x    <= POS_X_RST;
      pos_y    <= POS_Y_RST;
      vx       <= '0;
      vy       <= '0;
      heading  <= '0;
      rot_cnt  <= '0;
      cooldown <= '0;
      fire     <= 1'b0;
    end else begin
      fire <= tick & fire_nxt;   // self-clears on every non-tick clk
      if (tick) begin
        pos_x    <= pos_x_nxt;
        pos_y    <= pos_y_nxt;
        vx       <= vx_nxt;
        vy       <= vy_nxt;
        heading  <= heading_nxt;
        rot_cnt  <= rot_cnt_nxt;
        cooldown <= cooldown_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ship_control.sv
// ---------------------------------------------------------------------------
// tb_ship_control
//   Directed and randomized stimulus for ship_control (TICK_DIV = 4) checked
//   every clk against a behavioural model built from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ship_control;

  localparam int TICK_DIV      = 4;
  localparam int ROT_PERIOD    = 4;
  localparam int MAX_V         = 32;
  localparam int FIRE_COOLDOWN = 15;
  localparam int SPAN_X        = 160 * 16;
  localparam int SPAN_Y        = 120 * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shoot = 1'b0, forward = 1'b0, backward = 1'b0;
  logic       rotate_right = 1'b0, rotate_left = 1'b0;
  logic [7:0] ship_x;
  logic [6:0] ship_y;
  logic [3:0] heading;
  logic       fire, frame_tick;

  int checks = 0;
  int errors = 0;

  // Model state: positions in 1/16 px, velocities in 1/16 px/tick.
  int m_cyc, m_px, m_py, m_h, m_vx, m_vy, m_rot, m_cd;
  bit m_fire;
  bit m_live = 1'b0;

  int fire_cnt = 0;
  int wrap_x = 0, wrap_y = 0;

  ship_control #(
    .TICK_DIV      (TICK_DIV),
    .ROT_PERIOD    (ROT_PERIOD),
    .MAX_V         (MAX_V),
    .FIRE_COOLDOWN (FIRE_COOLDOWN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .shoot        (shoot),
    .forward      (forward),
    .backward     (backward),
    .rotate_right (rotate_right),
    .rotate_left  (rotate_left),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .heading      (heading),
    .fire         (fire),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Direction from trigonometry: (round(8 sin), -round(8 cos)).
  function automatic int dir_x(input int h);
    real a;
    a = h * 3.14159265358979 / 8.0;
    return $rtoi($floor(8.0 * $sin(a) + 0.5));
  endfunction

  function automatic int dir_y(input int h);
    real a;
    a = h * 3.14159265358979 / 8.0;
    return -$rtoi($floor(8.0 * $cos(a) + 0.5));
  endfunction

  function automatic int clampv(input int v);
    if (v > MAX_V) return MAX_V;
    if (v < -MAX_V) return -MAX_V;
    return v;
  endfunction

  function automatic int toward0(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic model_step();
    int s;
    if (reset) begin
      m_px = 1280; m_py = 960; m_h = 0; m_vx = 0; m_vy = 0;
      m_rot = 0; m_cd = 0; m_fire = 1'b0; m_cyc = 0; m_live = 1'b1;
    end else if (m_live) begin
      m_fire = 1'b0;
      if (m_cyc == TICK_DIV - 1) begin
        m_px = ((m_px + m_vx) % SPAN_X + SPAN_X) % SPAN_X;
        m_py = ((m_py + m_vy) % SPAN_Y + SPAN_Y) % SPAN_Y;
        if (shoot && m_cd == 0) begin
          m_fire = 1'b1;
          m_cd   = FIRE_COOLDOWN;
        end else if (m_cd > 0) begin
          m_cd--;
        end
        if (forward != backward) begin
          s    = forward ? 1 : -1;
          m_vx = clampv(m_vx + s * dir_x(m_h));
          m_vy = clampv(m_vy + s * dir_y(m_h));
        end else begin
          m_vx = toward0(m_vx);
          m_vy = toward0(m_vy);
        end
        if (rotate_right != rotate_left) begin
          m_rot++;
          if (m_rot == ROT_PERIOD) begin
            m_rot = 0;
            m_h   = (m_h + (rotate_right ? 1 : 15)) % 16;
          end
        end else begin
          m_rot = 0;
        end
      end
      m_cyc = (m_cyc + 1) % TICK_DIV;
    end
  endtask

  // Model advances on the active edge with the inputs the DUT also sees.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process, sampled on the opposite edge.
  initial begin
    int px, py;
    px = -1;
    py = -1;
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("ship_x", ship_x, m_px >> 4);
        check("ship_y", ship_y, m_py >> 4);
        check("heading", heading, m_h);
        check("fire", fire, m_fire);
        check("frame_tick", frame_tick, m_cyc == TICK_DIV - 1);
        check("x_in_range", ship_x < 8'd160, 1'b1);
        check("y_in_range", ship_y < 7'd120, 1'b1);
        if (fire === 1'b1) fire_cnt++;
        if (px >= 0 && (int'(ship_x) - px > 80 || px - int'(ship_x) > 80)) wrap_x++;
        if (py >= 0 && (int'(ship_y) - py > 60 || py - int'(ship_y) > 60)) wrap_y++;
        px = int'(ship_x);
        py = int'(ship_y);
      end
    end
  end

  // Any window of n*TICK_DIV clks contains exactly n game ticks.
  task automatic hold_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
    #1;
  endtask

  initial begin
    int base, guard;

    // Pin the model's direction table to hand-computed entries.
    check("dir0_dx", dir_x(0), 0);
    check("dir0_dy", dir_y(0), -8);
    check("dir4_dx", dir_x(4), 8);
    check("dir4_dy", dir_y(4), 0);
    check("dir2_dx", dir_x(2), 6);
    check("dir2_dy", dir_y(2), -6);

    // Reset and idle.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_x", ship_x, 80);
    check("rst_y", ship_y, 60);
    check("rst_heading", heading, 0);
    check("rst_fire", fire, 0);
    hold_ticks(20);
    check("idle_x", ship_x, 80);
    check("idle_y", ship_y, 60);
    check("idle_fires", fire_cnt, 0);

    // One tick of thrust at heading 0, then coast one tick: 960 - 8 = 952.
    forward = 1'b1;
    hold_ticks(1);
    forward = 1'b0;
    hold_ticks(1);
    check("thrust_y", ship_y, 59);
    check("thrust_x", ship_x, 80);
    forward = 1'b1;
    hold_ticks(10);
    forward = 1'b0;
    hold_ticks(40);

    // Rotation.
    rotate_right = 1'b1;
    hold_ticks(16);
    rotate_right = 1'b0;
    check("rot_r16", heading, 4);
    rotate_left = 1'b1;
    hold_ticks(4);
    check("rot_l4", heading, 3);
    rotate_right = 1'b1;
    hold_ticks(20);
    check("rot_both", heading, 3);
    rotate_right = 1'b0;
    hold_ticks(16);
    check("rot_to_15", heading, 15);
    rotate_left  = 1'b0;
    rotate_right = 1'b1;
    hold_ticks(17);
    check("rot_wrap", heading, 3);
    rotate_right = 1'b0;
    hold_ticks(1);

    // Auto-fire: ticks 0, 16, 32 of a 40-tick hold.
    base  = fire_cnt;
    shoot = 1'b1;
    hold_ticks(40);
    shoot = 1'b0;
    check("autofire_cnt", fire_cnt - base, 3);
    hold_ticks(16);
    // Release at tick 5, press at tick 10: nothing through tick 15, fire at 16.
    base  = fire_cnt;
    shoot = 1'b1;
    hold_ticks(5);
    shoot = 1'b0;
    hold_ticks(5);
    shoot = 1'b1;
    hold_ticks(6);
    check("cooldown_t15", fire_cnt - base, 1);
    hold_ticks(1);
    check("cooldown_t16", fire_cnt - base, 2);
    shoot = 1'b0;

    // Horizontal wrap at heading 4.
    rotate_right = 1'b1;
    guard = 0;
    while (m_h != 4 && guard < 40) begin
      hold_ticks(1);
      guard++;
    end
    rotate_right = 1'b0;
    check("face_right", heading, 4);
    forward = 1'b1;
    hold_ticks(150);
    forward = 1'b0;
    check("x_wrapped", wrap_x > 0, 1'b1);

    // Vertical wrap at heading 0.
    rotate_left = 1'b1;
    guard = 0;
    while (m_h != 0 && guard < 80) begin
      hold_ticks(1);
      guard++;
    end
    rotate_left = 1'b0;
    check("face_up", heading, 0);
    forward = 1'b1;
    hold_ticks(150);
    forward = 1'b0;
    check("y_wrapped", wrap_y > 0, 1'b1);

    // Randomized controls, one new combination per tick.
    repeat (300) begin
      shoot        = 1'($urandom_range(0, 1));
      forward      = ($urandom_range(0, 3) != 0);
      backward     = ($urandom_range(0, 3) == 0);
      rotate_right = 1'($urandom_range(0, 1));
      rotate_left  = 1'($urandom_range(0, 1));
      hold_ticks(1);
    end

    // Mid-flight reset for one clk with shoot held.
    forward = 1'b0; backward = 1'b0; rotate_right = 1'b0; rotate_left = 1'b0;
    shoot = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_x", ship_x, 80);
    check("mid_rst_y", ship_y, 60);
    check("mid_rst_heading", heading, 0);
    check("mid_rst_fire", fire, 0);
    base = fire_cnt;
    hold_ticks(1);
    check("fire_after_rst", fire_cnt - base, 1);
    shoot = 1'b0;
    hold_ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
